// File: rtl/cursor_step_controller_if.sv
// Cursor step controller bus: direction/step/jump inputs and cursor position outputs.
interface cursor_step_controller_if;
    logic [3:0] dir;
    logic       step_btn;
    logic       jump_req;
    logic [3:0] jump_row;
    logic [3:0] jump_col;
    logic [3:0] row;
    logic [3:0] col;
    logic [6:0] cell_idx;
    logic       moved;
    logic       wrapped;
    logic       busy;

    modport master (
        output dir, step_btn, jump_req, jump_row, jump_col,
        input  row, col, cell_idx, moved, wrapped, busy
    );

    modport slave (
        input  dir, step_btn, jump_req, jump_row, jump_col,
        output row, col, cell_idx, moved, wrapped, busy
    );
endinterface

// File: rtl/cursor_step_controller.sv
// Sudoku cursor sequencer: step button with auto-repeat, wrap-around, direct jumps.
// Optional fixed-cell skip search enabled by macro CURSOR_SKIP_FIXED_EN.
//
// state  | meaning
// IDLE   | waiting for a step_btn rising edge
// HOLD   | first step issued, counting DELAY_CYCLES before auto-repeat
// REPEAT | auto-repeat, one step every RATE_CYCLES while held
module cursor_step_controller #(
    parameter int GRID_SIZE    = 9,
    parameter int DELAY_CYCLES = 25000000,
    parameter int RATE_CYCLES  = 5000000
) (
    input  logic clk,
    input  logic rst,
`ifdef CURSOR_SKIP_FIXED_EN
    input  logic [GRID_SIZE*GRID_SIZE-1:0] fixed_mask,
`endif
    cursor_step_controller_if.slave bus
);
    localparam int         MAXC = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int         CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DLY_LOAD  = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RATE_LOAD = CW'(RATE_CYCLES - 1);
    localparam logic [3:0] GMAX = 4'(GRID_SIZE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          btn_prev;
    logic          issue;
    logic [3:0]    row_q, col_q, row_n, col_n;
    logic [6:0]    cell_q, cell_n;
    logic          moved_q, moved_n, wrapped_q, wrapped_n;
    logic [3:0]    row_s, col_s;
    logic          wx, wy, moving, jump_ok;

    function automatic logic [4:0] step_axis(input logic en, input logic up, input logic [3:0] p);
        if (!en) return {1'b0, p};
        if (up)  return (p == GMAX) ? 5'b10000 : {1'b0, p + 4'd1};
        return (p == 4'd0) ? {1'b1, GMAX} : {1'b0, p - 4'd1};
    endfunction

    function automatic logic [6:0] cell_of(input logic [3:0] r, input logic [3:0] c);
        return 7'(r) * 7'(GRID_SIZE) + 7'(c);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_prev <= bus.step_btn;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.step_btn && !btn_prev) begin
                    issue     = 1'b1;
                    cnt_nxt   = DLY_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!bus.step_btn) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    issue     = 1'b1;
                    cnt_nxt   = RATE_LOAD;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign {wx, col_s} = step_axis(bus.dir[0], bus.dir[1], col_q);
    assign {wy, row_s} = step_axis(bus.dir[2], bus.dir[3], row_q);
    assign moving  = bus.dir[0] | bus.dir[2];
    assign jump_ok = bus.jump_req && (bus.jump_row <= GMAX) && (bus.jump_col <= GMAX);

`ifdef CURSOR_SKIP_FIXED_EN
    localparam logic [3:0] SRCH_LAST = 4'(GRID_SIZE - 1);
    logic       srch_q, srch_n, srch_wrap_q, srch_wrap_n;
    logic [3:0] srch_row_q, srch_row_n, srch_col_q, srch_col_n;
    logic [3:0] srch_dir_q, srch_dir_n, srch_cnt_q, srch_cnt_n, srch_cnt_inc;
    logic [3:0] srow_s, scol_s;
    logic       swx, swy;

    assign {swx, scol_s} = step_axis(srch_dir_q[0], srch_dir_q[1], srch_col_q);
    assign {swy, srow_s} = step_axis(srch_dir_q[2], srch_dir_q[3], srch_row_q);
    assign srch_cnt_inc  = srch_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            srch_q      <= 1'b0;
            srch_wrap_q <= 1'b0;
            srch_row_q  <= '0;
            srch_col_q  <= '0;
            srch_dir_q  <= '0;
            srch_cnt_q  <= '0;
        end else begin
            srch_q      <= srch_n;
            srch_wrap_q <= srch_wrap_n;
            srch_row_q  <= srch_row_n;
            srch_col_q  <= srch_col_n;
            srch_dir_q  <= srch_dir_n;
            srch_cnt_q  <= srch_cnt_n;
        end
    end
    assign bus.busy = srch_q;
`else
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        row_n     = row_q;
        col_n     = col_q;
        moved_n   = 1'b0;
        wrapped_n = 1'b0;
`ifdef CURSOR_SKIP_FIXED_EN
        srch_n      = srch_q;
        srch_wrap_n = srch_wrap_q;
        srch_row_n  = srch_row_q;
        srch_col_n  = srch_col_q;
        srch_dir_n  = srch_dir_q;
        srch_cnt_n  = srch_cnt_q;
`endif
        if (jump_ok) begin
            row_n   = bus.jump_row;
            col_n   = bus.jump_col;
            moved_n = 1'b1;
`ifdef CURSOR_SKIP_FIXED_EN
            srch_n  = 1'b0;
        end else if (srch_q) begin
            // The last candidate of a full lap is the starting cell itself: give up.
            if (srch_cnt_inc == SRCH_LAST) begin
                srch_n = 1'b0;
            end else if (!fixed_mask[cell_of(srow_s, scol_s)]) begin
                row_n     = srow_s;
                col_n     = scol_s;
                moved_n   = 1'b1;
                wrapped_n = srch_wrap_q | swx | swy;
                srch_n    = 1'b0;
            end else begin
                srch_row_n  = srow_s;
                srch_col_n  = scol_s;
                srch_cnt_n  = srch_cnt_inc;
                srch_wrap_n = srch_wrap_q | swx | swy;
            end
        end else if (issue && moving) begin
            if (fixed_mask[cell_of(row_s, col_s)]) begin
                srch_n      = 1'b1;
                srch_row_n  = row_s;
                srch_col_n  = col_s;
                srch_dir_n  = bus.dir;
                srch_wrap_n = wx | wy;
                srch_cnt_n  = '0;
            end else begin
                row_n     = row_s;
                col_n     = col_s;
                moved_n   = 1'b1;
                wrapped_n = wx | wy;
            end
        end
`else
        end else if (issue && moving) begin
            row_n     = row_s;
            col_n     = col_s;
            moved_n   = 1'b1;
            wrapped_n = wx | wy;
        end
`endif
    end

    assign cell_n = cell_of(row_n, col_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            cell_q    <= '0;
            moved_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            row_q     <= row_n;
            col_q     <= col_n;
            cell_q    <= cell_n;
            moved_q   <= moved_n;
            wrapped_q <= wrapped_n;
        end
    end

    assign bus.row      = row_q;
    assign bus.col      = col_q;
    assign bus.cell_idx = cell_q;
    assign bus.moved    = moved_q;
    assign bus.wrapped  = wrapped_q;
endmodule

// File: tb/tb_cursor_step_controller.sv
// Self-checking bench for cursor_step_controller against a press-age based cursor model.
module tb_cursor_step_controller;
    localparam int G = 9;
    localparam int D = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cursor_step_controller_if bus ();
`ifdef CURSOR_SKIP_FIXED_EN
    logic [G*G-1:0] fixed_mask;
`endif

    cursor_step_controller #(.GRID_SIZE(G), .DELAY_CYCLES(D), .RATE_CYCLES(R)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CURSOR_SKIP_FIXED_EN
        .fixed_mask (fixed_mask),
`endif
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: position plus the age of the current press in cycles (-1 = no live press).
    int mrow, mcol, mprev, mage;
    int exp_moved, exp_wrapped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_axis_model(input int up, inout int p, inout int w);
        int n;
        n = p + (up != 0 ? 1 : -1);
        if (n < 0 || n >= G) w = 1;
        p = (n + G) % G;
    endtask

    task automatic tick(input string tag, input logic r, input logic btn, input logic [3:0] d,
                        input logic jr, input int jrow, input int jcol);
        int issue, w;
        rst          = r;
        bus.step_btn = btn;
        bus.dir      = d;
        bus.jump_req = jr;
        bus.jump_row = 4'(jrow);
        bus.jump_col = 4'(jcol);
        exp_moved   = 0;
        exp_wrapped = 0;
        if (r) begin
            mrow = 0; mcol = 0; mprev = 1; mage = -1;
        end else begin
            issue = 0;
            if (!btn) begin
                mage = -1;
            end else if (mprev == 0) begin
                mage  = 0;
                issue = 1;
            end else if (mage >= 0) begin
                mage++;
                issue = (mage >= D) && ((mage - D) % R == 0);
            end
            mprev = btn;
            if (jr && jrow < G && jcol < G) begin
                mrow = jrow; mcol = jcol; exp_moved = 1;
            end else if (issue && (d[0] || d[2])) begin
                w = 0;
                if (d[0]) step_axis_model(d[1], mcol, w);
                if (d[2]) step_axis_model(d[3], mrow, w);
                exp_moved   = 1;
                exp_wrapped = w;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".row"},     32'(bus.row),      32'(mrow));
        chk({tag, ".col"},     32'(bus.col),      32'(mcol));
        chk({tag, ".cell"},    32'(bus.cell_idx), 32'(mrow * G + mcol));
        chk({tag, ".moved"},   32'(bus.moved),    32'(exp_moved));
        chk({tag, ".wrapped"}, 32'(bus.wrapped),  32'(exp_wrapped));
        chk({tag, ".busy"},    32'(bus.busy),     32'd0);
    endtask

`ifdef CURSOR_SKIP_FIXED_EN
    task automatic skip_case(input string tag, input int exp_busy, input int exp_col, input int exp_moves);
        int nb, nm;
        nb = 0; nm = 0;
        bus.step_btn = 1'b1;
        bus.dir      = 4'b0011;
        bus.jump_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            bus.step_btn = 1'b0;
            if (bus.busy) nb++;
            if (bus.moved) nm++;
        end
        chk({tag, ".busy_cycles"}, 32'(nb),      32'(exp_busy));
        chk({tag, ".moves"},       32'(nm),      32'(exp_moves));
        chk({tag, ".col"},         32'(bus.col), 32'(exp_col));
        chk({tag, ".row"},         32'(bus.row), 32'd0);
    endtask
`endif

    initial begin
        logic       rb, rj;
        logic [3:0] rd;
        rst = 1'b1;
        bus.step_btn = 1'b0; bus.dir = 4'b0; bus.jump_req = 1'b0;
        bus.jump_row = 4'd0; bus.jump_col = 4'd0;
`ifdef CURSOR_SKIP_FIXED_EN
        fixed_mask = '0;
`endif
        mrow = 0; mcol = 0; mprev = 1; mage = -1;

        tick("reset", 1, 0, 4'b0000, 0, 0, 0);
        tick("reset2", 1, 0, 4'b0000, 0, 0, 0);

        // Single press, right.
        tick("idle", 0, 0, 4'b0011, 0, 0, 0);
        tick("single", 0, 1, 4'b0011, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick("single_after", 0, 0, 4'b0011, 0, 0, 0);

        // Held left from origin: wrap, delay, then repeat.
        tick("rst_b", 1, 0, 4'b0001, 0, 0, 0);
        tick("idle_b", 0, 0, 4'b0001, 0, 0, 0);
        tick("hold_press", 0, 1, 4'b0001, 0, 0, 0);
        chk("hold_press.col8", 32'(bus.col), 32'd8);
        chk("hold_press.wrap", 32'(bus.wrapped), 32'd1);
        for (int i = 0; i < 12; i++) tick("hold", 0, 1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick("release", 0, 0, 4'b0001, 0, 0, 0);

        // Jump beats a same-cycle step; out-of-range jump ignored.
        tick("jump_step", 0, 1, 4'b0011, 1, 4, 7);
        chk("jump.cell43", 32'(bus.cell_idx), 32'd43);
        tick("jump_hold", 0, 1, 4'b0011, 0, 0, 0);
        tick("jump_rel", 0, 0, 4'b0011, 0, 0, 0);
        tick("jump_bad", 0, 0, 4'b0011, 1, 9, 2);
        tick("jump_bad2", 0, 0, 4'b0011, 1, 3, 12);

        // Reset during REPEAT with the button still held.
        for (int i = 0; i < 9; i++) tick("rep", 0, 1, 4'b0101, 0, 0, 0);
        tick("rst_rep", 1, 1, 4'b0101, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick("held_thru_rst", 0, 1, 4'b0101, 0, 0, 0);
        tick("rel2", 0, 0, 4'b0101, 0, 0, 0);
        tick("repress", 0, 1, 4'b0101, 0, 0, 0);
        tick("rel3", 0, 0, 4'b0101, 0, 0, 0);

        // No direction, then row wrap upward from row 8.
        tick("dir0", 0, 1, 4'b0000, 0, 0, 0);
        tick("dir0_rel", 0, 0, 4'b0000, 0, 0, 0);
        tick("jump83", 0, 0, 4'b1100, 1, 8, 3);
        tick("rowwrap", 0, 1, 4'b1100, 0, 0, 0);
        chk("rowwrap.row0", 32'(bus.row), 32'd0);
        tick("rowwrap_rel", 0, 0, 4'b1100, 0, 0, 0);

        // Randomized traffic.
        rb = 1'b0; rd = 4'b0011;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            if ($urandom_range(0, 5) == 0) rd = 4'($urandom_range(0, 15));
            rj = ($urandom_range(0, 15) == 0);
            tick("rand", ($urandom_range(0, 99) == 0), rb, rd, rj,
                 int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
        end

`ifdef CURSOR_SKIP_FIXED_EN
        fixed_mask = '0;
        fixed_mask[1] = 1'b1;
        fixed_mask[2] = 1'b1;
        tick("skip_rst", 1, 0, 4'b0011, 0, 0, 0);
        tick("skip_idle", 0, 0, 4'b0011, 0, 0, 0);
        skip_case("skip2", 2, 3, 1);
        fixed_mask = '0;
        for (int c = 1; c < G; c++) fixed_mask[c] = 1'b1;
        tick("skip_rst2", 1, 0, 4'b0011, 0, 0, 0);
        tick("skip_idle2", 0, 0, 4'b0011, 0, 0, 0);
        skip_case("skipall", 8, 0, 0);
        fixed_mask = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cursor_step_controller.md
Name: cursor_step_controller

Overview:
- Sequences the Sudoku cursor's row/column position from the 4-bit direction code produced by the direction controller.
- Converts a debounced step button into single steps and auto-repeat steps, with wrap-around on the 9x9 grid.
- Arbitrates step moves against direct jump requests; jump requests come from the cell-select / game-reset logic.
- Feeds row/col/cell index to the board RAM addressing and the display highlight logic.

Parameters:
- GRID_SIZE, 9, cells per row/column; legal positions are 0..GRID_SIZE-1.
- DELAY_CYCLES, 25000000, cycles step_btn must stay held after the first step before auto-repeat starts.
- RATE_CYCLES, 5000000, cycles between auto-repeat steps.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dir  in  4  direction code: bit0 x(col) enable, bit1 x up(1)/down(0), bit2 y(row) enable, bit3 y up/down
- step_btn  in  1  debounced level; held high for auto-repeat
- jump_req  in  1  one-cycle request to load jump_row/jump_col
- jump_row  in  4  target row
- jump_col  in  4  target column
- row  out  4  registered cursor row
- col  out  4  registered cursor column
- cell_idx  out  7  registered row*GRID_SIZE+col
- moved  out  1  one-cycle pulse, asserted in the first cycle a new position is visible
- wrapped  out  1  one-cycle pulse with moved when any axis wrapped during that move
- busy  out  1  skip search in progress (tied 0 without the optional feature)

Behaviour:
- Reset (rst high at a clk edge): row=0, col=0, cell_idx=0, moved=0, wrapped=0, busy=0, FSM=IDLE, counter=0.
  - Step-button history register resets to 1, so a button held through reset never produces a step.
- Rising edge of step_btn is detected as step_btn=1 with previous sample 0.
- FSM states:
  - IDLE: on rising edge -> issue step, load counter=DELAY_CYCLES-1, go to HOLD.
  - HOLD: step_btn=0 -> IDLE. Counter==0 -> issue step, load RATE_CYCLES-1, go to REPEAT. Otherwise decrement.
  - REPEAT: step_btn=0 -> IDLE. Counter==0 -> issue step, reload RATE_CYCLES-1. Otherwise decrement.
- Issuing a step:
  - Latency: new row/col/cell_idx, moved and wrapped appear after the same clk edge that samples the issue condition.
  - dir is sampled at each issue; a dir change mid-repeat affects the next step.
  - x enabled: col +/-1 per bit1. y enabled: row +/-1 per bit3. Both enabled: both axes move (diagonal).
  - Neither enabled: no position change, no moved pulse; the FSM still advances.
- Wrap-around: increment at GRID_SIZE-1 -> 0; decrement at 0 -> GRID_SIZE-1; wrapped=1.
- Jump:
  - jump_req with jump_row<GRID_SIZE and jump_col<GRID_SIZE loads both, pulses moved, wrapped=0.
  - Out-of-range jump is ignored with no pulse.
  - Jump has priority over a step issued in the same cycle; that step is dropped, not retried, and the FSM/counter continue normally.
- cell_idx is computed from the next-state row/col and registered together with them; it is never skewed.

Optional Feature:
- Macro: CURSOR_SKIP_FIXED_EN.
- Enabled:
  - Adds input fixed_mask [GRID_SIZE*GRID_SIZE-1:0] (bit row*GRID_SIZE+col = given clue).
  - A step that lands on a fixed cell does not update outputs; it enters SEARCH with busy=1.
  - SEARCH advances one cell per cycle in the captured dir, with wrap, until a non-fixed cell is found.
  - On finding one: outputs update with a single moved pulse; wrapped is set if any wrap occurred in the whole move.
  - If GRID_SIZE-1 further cells are all fixed: position unchanged, no moved pulse, busy drops.
  - While busy, step issues are ignored; jump_req aborts the search and jumps (jumps ignore fixed_mask).
- Disabled: no fixed_mask port, busy tied 0, steps land on any cell.

Test Plan:
- Bench parameters: GRID_SIZE=9, DELAY_CYCLES=4, RATE_CYCLES=2.
- Reset, dir=0011, step_btn high 1 cycle -> col 0->1, cell_idx=1, moved one cycle, wrapped=0, no further steps.
- From (0,0), dir=0001, step_btn held -> col=8 with wrapped=1 at the press edge; col=7 four cycles later; then 6, 5, ... every 2 cycles; release -> stepping stops.
- jump_req (row 4, col 7) in the same cycle as a step rising edge -> row=4, col=7, cell_idx=43, one moved pulse; step dropped. jump_row=9 -> no change, no moved.
- rst during REPEAT with step_btn held -> all outputs 0. Button still held after reset -> no step until released and pressed again.
- dir=0000 plus a step press -> no position change, no moved. dir=1100 from row 8 -> row=0, wrapped=1.
- CURSOR_SKIP_FIXED_EN: fixed cells (0,1),(0,2), dir=0011 from (0,0) -> busy for 2 cycles, col=3, one moved pulse. Row 0 all fixed except col 0 -> busy for 8 cycles, col stays 0, no moved.
